rijndael_round_ctrl: RTL and testbench
======================================

Name: rijndael_round_ctrl

Overview:
- Iterative Rijndael encryption sequencer. Owns the STATESIZE-bit state register and the round counter.
- Fetches round keys from an external key-schedule unit over a request/valid handshake.
- Drives an external combinational round-function unit (SubBytes, ShiftRows, MixColumns, AddRoundKey) once per round.
- Sits between the block-level valid/ready stream and the round datapath; supports all Rijndael NB/NK combinations.

Parameters:
- NB, 4, block size in 32-bit columns; legal values 4, 6, 8.
- NK, 4, key size in 32-bit words; legal values 4, 6, 8.
- STATESIZE (localparam), 32*NB, state width in bits.
- NR (localparam), max(NB,NK)+6, number of rounds (10..14).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- in_valid_i  in  1  input block valid
- in_ready_o  out  1  controller can accept a block
- in_block_i  in  STATESIZE  plaintext block
- rk_req_o  out  1  round-key request
- rk_idx_o  out  4  requested round-key index (0..NR)
- rk_valid_i  in  1  rk_i valid for rk_idx_o
- rk_i  in  STATESIZE  round key
- rnd_state_o  out  STATESIZE  state register value, fed to the round unit
- rnd_key_o  out  STATESIZE  equals rk_i (pass-through)
- rnd_final_o  out  1  final round: round unit skips MixColumns
- rnd_result_i  in  STATESIZE  round-unit output, combinational from rnd_state_o, rnd_key_o and rnd_final_o
- out_valid_o  out  1  ciphertext valid
- out_ready_i  in  1  downstream accepts
- out_block_o  out  STATESIZE  ciphertext
- busy_o  out  1  high in any state except IDLE

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- FSM states: IDLE, KEY, DONE.
- Reset values: state IDLE; state register 0; round counter 0; in_ready_o=1; rk_req_o=0; rk_idx_o=0; out_valid_o=0; out_block_o=0; busy_o=0.
- Reset applied mid-operation discards the block in flight, drops any pending key request, and returns to IDLE the next cycle. No partial output is produced.

IDLE:
- in_ready_o=1.
- On in_valid_i & in_ready_o: state reg <= in_block_i, round <= 0, go to KEY.

KEY:
- rk_req_o=1 and rk_idx_o=round, held stable until rk_valid_i.
- rk_valid_i is ignored whenever rk_req_o=0.
- On rk_valid_i with round==0: state <= state XOR rk_i (initial AddRoundKey), round <= 1.
- On rk_valid_i with 1<=round<NR: state <= rnd_result_i, round <= round+1.
- On rk_valid_i with round==NR: state <= rnd_result_i, go to DONE.
- rnd_final_o = (round==NR) & in KEY; otherwise 0.
- rnd_state_o always equals the state register.

DONE:
- out_valid_o=1 and out_block_o=state register, both stable until handshake.
- On out_ready_i: go to IDLE and clear the round counter.
- out_block_o is 0 outside DONE.

Ready/latency:
- in_ready_o=0 in KEY and DONE (but see optional feature).
- Latency with rk_valid_i tied high: accept at cycle 0, out_valid_o at cycle NR+1. Each cycle of rk_valid_i low adds one cycle.
- The round counter never exceeds NR and never wraps.
- Out-of-range NB or NK is a fatal elaboration error.

Optional Feature:
- Macro: RIJNDAEL_ROUND_CTRL_B2B_EN.
- Defined: in DONE, in_ready_o = out_ready_i. A simultaneous out_valid_o&out_ready_i and in_valid_i&in_ready_o completes the output and loads the new block, going directly to KEY with round 0 and no IDLE bubble. Sustained throughput is one block per NR+2 cycles.
- Undefined: in_ready_o=0 in DONE; each block passes through one IDLE cycle, giving one block per NR+3 cycles.

Test Plan:
- AES-128 (NB=4, NK=4), reference key-schedule and round-unit models, rk_valid_i=1. Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_block_o=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid_o 11 cycles after accept, rk_idx_o sequence 0..10, rnd_final_o high only at idx 10.
- Key stall: rk_valid_i low for 3 cycles while rk_idx_o=5 -> rk_req_o and rk_idx_o=5 held; same ciphertext at latency 14.
- Output backpressure: out_ready_i low for 4 cycles in DONE -> out_valid_o and out_block_o stable, in_ready_o=0, busy_o=1; IDLE the cycle after out_ready_i rises.
- Reset at rk_idx_o=7 -> next cycle all outputs at reset values. A following AES-128 FIPS-197 block produces the correct ciphertext.
- NB=8, NK=8 (Rijndael-256/256) against the reference model -> NR=14, rk_idx_o 0..14, rnd_final_o only at 14, result matches the model, latency 15.
- With RIJNDAEL_ROUND_CTRL_B2B_EN: two back-to-back blocks with out_ready_i=1 and in_valid_i=1 -> second block accepted in the first block's DONE cycle, outputs 12 cycles apart. Without the macro: outputs 13 cycles apart.

Source files
------------

// File: rtl/rijndael_round_ctrl.sv
// rijndael_round_ctrl -- iterative Rijndael encryption sequencer.
//
// Holds the cipher state register and the round counter. For each block it
// fetches round keys 0..NR from an external key-schedule unit over a
// request/valid handshake. It applies the initial AddRoundKey itself and uses
// an external combinational round unit for rounds 1..NR.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i/in_ready_o    plaintext stream handshake, in_block_i data
//   rk_req_o/rk_idx_o        round-key request and index (0..NR)
//   rk_valid_i/rk_i          round-key response
//   rnd_state_o/rnd_key_o    operands for the external round unit
//   rnd_final_o              last round: round unit skips MixColumns
//   rnd_result_i             round-unit result (combinational)
//   out_valid_o/out_ready_i  ciphertext stream handshake, out_block_o data
//   busy_o                   high whenever the controller is not idle
//
// Optional build macro RIJNDAEL_ROUND_CTRL_B2B_EN: when it is defined, a new
// block can be accepted in the same cycle the previous ciphertext is taken.
// This removes the idle bubble between blocks.
module rijndael_round_ctrl #(
  parameter int NB = 4,
  parameter int NK = 4,
  localparam int STATESIZE = 32 * NB
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [STATESIZE-1:0] in_block_i,
  output logic                 rk_req_o,
  output logic [3:0]           rk_idx_o,
  input  logic                 rk_valid_i,
  input  logic [STATESIZE-1:0] rk_i,
  output logic [STATESIZE-1:0] rnd_state_o,
  output logic [STATESIZE-1:0] rnd_key_o,
  output logic                 rnd_final_o,
  input  logic [STATESIZE-1:0] rnd_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [STATESIZE-1:0] out_block_o,
  output logic                 busy_o
);

  localparam int NR = ((NB > NK) ? NB : NK) + 6;
  localparam logic [3:0] NR_L = 4'(NR);

  if (!((NB == 4) || (NB == 6) || (NB == 8)) ||
      !((NK == 4) || (NK == 6) || (NK == 8))) begin : g_bad_param
    $fatal(1, "rijndael_round_ctrl: NB and NK must each be 4, 6 or 8");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           fsm_reg, fsm_next;
  logic [STATESIZE-1:0] data_reg, data_next;
  logic [3:0]           round_reg, round_next;
  logic                 in_fire, key_fire, out_fire;

`ifdef RIJNDAEL_ROUND_CTRL_B2B_EN
  // Accepting in DONE is only safe when the current ciphertext leaves in the
  // same cycle, so readiness follows the downstream ready.
  assign in_ready_o = (fsm_reg == S_IDLE) | ((fsm_reg == S_DONE) & out_ready_i);
`else
  assign in_ready_o = (fsm_reg == S_IDLE);
`endif

  assign rk_req_o    = (fsm_reg == S_KEY);
  assign rk_idx_o    = round_reg;
  assign rnd_state_o = data_reg;
  assign rnd_key_o   = rk_i;
  assign rnd_final_o = (fsm_reg == S_KEY) && (round_reg == NR_L);
  assign out_valid_o = (fsm_reg == S_DONE);
  assign out_block_o = out_valid_o ? data_reg : '0;
  assign busy_o      = (fsm_reg != S_IDLE);

  assign in_fire  = in_valid_i & in_ready_o;
  // A key response counts only while a request is outstanding.
  assign key_fire = rk_req_o & rk_valid_i;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    fsm_next   = fsm_reg;
    data_next  = data_reg;
    round_next = round_reg;
    case (fsm_reg)
      S_IDLE: begin
        if (in_fire) begin
          data_next  = in_block_i;
          round_next = 4'd0;
          fsm_next   = S_KEY;
        end
      end
      S_KEY: begin
        if (key_fire) begin
          if (round_reg == 4'd0) begin
            // Round 0 is a bare AddRoundKey, done here without the round unit.
            data_next  = data_reg ^ rk_i;
            round_next = 4'd1;
          end else begin
            data_next = rnd_result_i;
            // The counter stops at NR; DONE is entered instead of advancing.
            if (round_reg == NR_L) begin
              fsm_next = S_DONE;
            end else begin
              round_next = round_reg + 4'd1;
            end
          end
        end
      end
      S_DONE: begin
        if (out_fire) begin
          round_next = 4'd0;
          // in_fire can only be set here in the back-to-back build.
          if (in_fire) begin
            data_next = in_block_i;
            fsm_next  = S_KEY;
          end else begin
            fsm_next = S_IDLE;
          end
        end
      end
      default: begin
        fsm_next   = S_IDLE;
        round_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_reg   <= S_IDLE;
      data_reg  <= '0;
      round_reg <= 4'd0;
    end else begin
      fsm_reg   <= fsm_next;
      data_reg  <= data_next;
      round_reg <= round_next;
    end
  end

endmodule

// File: tb/tb_rijndael_round_ctrl.sv
// Directed bench for rijndael_round_ctrl. An AES-128 instance (NB=NK=4) and a
// Rijndael-256/256 instance (NB=NK=8) run side by side. The bench provides the
// key-schedule unit and the round unit as behavioural models.
module tb_rijndael_round_ctrl;

  localparam logic [255:0] PT128 = 256'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] CT128 = 256'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] PT2   = 256'hffeeddccbbaa99887766554433221100;
  localparam logic [255:0] PTB   = 256'h00112233445566778899aabbccddeeff_00112233445566778899aabbccddeeff;
  localparam logic [255:0] KB    = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
`ifdef RIJNDAEL_ROUND_CTRL_B2B_EN
  localparam int   GAP       = 12;
  localparam logic B2B_READY = 1'b1;
`else
  localparam int   GAP       = 13;
  localparam logic B2B_READY = 1'b0;
`endif

  // ---------------- reference models ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, r1, r2, r3, r4;
    inv = 8'h01; base = x;
    for (int i = 0; i < 8; i++) begin   // inverse as x^254
      if (i != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    r1 = {inv[6:0], inv[7]};
    r2 = {r1[6:0], r1[7]};
    r3 = {r2[6:0], r2[7]};
    r4 = {r3[6:0], r3[7]};
    return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [7:0] getb(input logic [255:0] v, input int nb, input int i);
    return v[32*nb-1-8*i -: 8];
  endfunction

  function automatic logic [255:0] rnd_fn(input logic [255:0] st, input logic [255:0] key,
                                          input int nb, input logic fin);
    logic [7:0] a [32];
    logic [7:0] b [32];
    logic [7:0] m [32];
    logic [255:0] res;
    int sh;
    res = '0;
    for (int i = 0; i < 32; i++) begin a[i] = 8'h00; b[i] = 8'h00; m[i] = 8'h00; end
    for (int i = 0; i < 4*nb; i++) a[i] = sbox(getb(st, nb, i));
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        sh = (nb == 8 && r >= 2) ? r + 1 : r;
        b[4*c+r] = a[4*((c+sh)%nb)+r];
      end
    for (int c = 0; c < nb; c++) begin
      if (fin) begin
        for (int r = 0; r < 4; r++) m[4*c+r] = b[4*c+r];
      end else begin
        m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    for (int i = 0; i < 4*nb; i++) res[32*nb-1-8*i -: 8] = m[i] ^ getb(key, nb, i);
    return res;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [255:0] rkey(input logic [255:0] key, input int nb, input int nk, input int r);
    logic [31:0] w [120];
    logic [31:0] t;
    logic [7:0] rc;
    logic [255:0] res;
    int nr;
    nr = ((nb > nk) ? nb : nk) + 6;
    rc = 8'h01; res = '0;
    for (int i = 0; i < 120; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[32*nk-1-32*i -: 32];
    for (int i = nk; i < nb*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < nb; j++) res[32*nb-1-32*j -: 32] = w[nb*r+j];
    return res;
  endfunction

  function automatic logic [255:0] enc(input logic [255:0] pt, input logic [255:0] key,
                                       input int nb, input int nk);
    logic [255:0] s;
    int nr;
    nr = ((nb > nk) ? nb : nk) + 6;
    s = pt ^ rkey(key, nb, nk, 0);
    for (int r = 1; r <= nr; r++) s = rnd_fn(s, rkey(key, nb, nk, r), nb, (r == nr));
    return s;
  endfunction

  // ---------------- stimulus signals and DUTs ----------------
  logic clk = 1'b0;
  logic rst, sel, in_valid, rkv, out_ready;
  logic [255:0] in_block;
  logic [255:0] rka [16];
  logic [255:0] rkb [16];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic a_in_ready, a_rk_req, a_final, a_out_valid, a_busy, a_in_valid;
  logic [3:0] a_rk_idx;
  logic [127:0] a_in_block, a_rk, a_rnd_state, a_rnd_key, a_rnd_result, a_out_block;
  logic [255:0] a_res_w;

  assign a_in_valid = in_valid & ~sel;
  assign a_in_block = in_block[127:0];
  assign a_rk = rka[a_rk_idx][127:0];
  always_comb a_res_w = rnd_fn({128'h0, a_rnd_state}, {128'h0, a_rnd_key}, 4, a_final);
  assign a_rnd_result = a_res_w[127:0];

  rijndael_round_ctrl #(.NB(4), .NK(4)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_block_i(a_in_block),
    .rk_req_o(a_rk_req), .rk_idx_o(a_rk_idx), .rk_valid_i(rkv), .rk_i(a_rk),
    .rnd_state_o(a_rnd_state), .rnd_key_o(a_rnd_key), .rnd_final_o(a_final),
    .rnd_result_i(a_rnd_result),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready & ~sel), .out_block_o(a_out_block),
    .busy_o(a_busy)
  );

  logic b_in_ready, b_rk_req, b_final, b_out_valid, b_busy, b_in_valid;
  logic [3:0] b_rk_idx;
  logic [255:0] b_rk, b_rnd_state, b_rnd_key, b_rnd_result, b_out_block;

  assign b_in_valid = in_valid & sel;
  assign b_rk = rkb[b_rk_idx];
  always_comb b_rnd_result = rnd_fn(b_rnd_state, b_rnd_key, 8, b_final);

  rijndael_round_ctrl #(.NB(8), .NK(8)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_block_i(in_block),
    .rk_req_o(b_rk_req), .rk_idx_o(b_rk_idx), .rk_valid_i(rkv), .rk_i(b_rk),
    .rnd_state_o(b_rnd_state), .rnd_key_o(b_rnd_key), .rnd_final_o(b_final),
    .rnd_result_i(b_rnd_result),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready & sel), .out_block_o(b_out_block),
    .busy_o(b_busy)
  );

  // Observation view of whichever instance is selected.
  logic o_in_ready, o_req, o_final, o_valid, o_busy;
  logic [3:0] o_idx;
  logic [255:0] o_state, o_key, o_block;
  assign o_in_ready = sel ? b_in_ready  : a_in_ready;
  assign o_req      = sel ? b_rk_req    : a_rk_req;
  assign o_final    = sel ? b_final     : a_final;
  assign o_valid    = sel ? b_out_valid : a_out_valid;
  assign o_busy     = sel ? b_busy      : a_busy;
  assign o_idx      = sel ? b_rk_idx    : a_rk_idx;
  assign o_state    = sel ? b_rnd_state : {128'h0, a_rnd_state};
  assign o_key      = sel ? b_rnd_key   : {128'h0, a_rnd_key};
  assign o_block    = sel ? b_out_block : {128'h0, a_out_block};

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 1);
    chk({tag, "_rk_req"}, o_req, 0);
    chk({tag, "_rk_idx"}, o_idx, 0);
    chk({tag, "_out_valid"}, o_valid, 0);
    chk({tag, "_out_block"}, o_block, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_final"}, o_final, 0);
  endtask

  // One block through the selected instance, optional key stall and
  // output backpressure.
  task automatic run_block(input string tag, input logic [255:0] pt, input logic [255:0] ct,
                           input int nr, input int stall_idx, input int stall_n,
                           input int lat, input int hold_n);
    int cyc, idx, left;
    bit ark_done;
    logic [255:0] rk0;
    rk0 = sel ? rkb[0] : rka[0];
    chk({tag, "_idle_ready"}, o_in_ready, 1);
    in_block = pt; in_valid = 1'b1; rkv = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 0; idx = 0; left = stall_n; ark_done = 0;
    while (o_valid !== 1'b1 && cyc < 60) begin
      chk({tag, "_rk_req"}, o_req, 1);
      chk({tag, "_rk_idx"}, o_idx, idx);
      chk({tag, "_final"}, o_final, (idx == nr));
      chk({tag, "_busy_key"}, o_busy, 1);
      chk({tag, "_ready_key"}, o_in_ready, 0);
      chk({tag, "_rnd_key"}, o_key, sel ? rkb[idx] : rka[idx]);
      if (idx == 1 && !ark_done) begin
        chk({tag, "_initial_ark"}, o_state, pt ^ rk0);
        ark_done = 1;
      end
      if (idx == stall_idx && left > 0) begin
        rkv = 1'b0;
        left--;
      end else begin
        rkv = 1'b1;
      end
      tick();
      cyc++;
      if (rkv) idx++;
    end
    rkv = 1'b1;
    chk({tag, "_out_valid"}, o_valid, 1);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_ciphertext"}, o_block, ct);
    for (int h = 0; h < hold_n; h++) begin
      chk({tag, "_hold_valid"}, o_valid, 1);
      chk({tag, "_hold_block"}, o_block, ct);
      chk({tag, "_hold_ready"}, o_in_ready, 0);
      chk({tag, "_hold_busy"}, o_busy, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, o_valid, 0);
    chk({tag, "_post_busy"}, o_busy, 0);
    chk({tag, "_post_ready"}, o_in_ready, 1);
    chk({tag, "_post_block"}, o_block, 0);
    $display("block %s: ciphertext=%h latency=%0d", tag, o_block, cyc);
  endtask

  // ---------------- directed sequence ----------------
  logic [255:0] ct2, ctb;
  int first_out, second_out;

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; rkv = 1'b1; out_ready = 1'b0; in_block = '0;
    for (int r = 0; r < 16; r++) begin
      rka[r] = (r <= 10) ? rkey(K128, 4, 4, r) : '0;
      rkb[r] = (r <= 14) ? rkey(KB, 8, 8, r) : '0;
    end
    ct2 = enc(PT2, K128, 4, 4);
    ctb = enc(PTB, KB, 8, 8);

    tick(); tick();
    check_reset("reset_a");
    sel = 1'b1; #1; check_reset("reset_b"); sel = 1'b0; #1;
    rst = 1'b0;
    tick();

    // FIPS-197 AES-128 block, keys always available.
    run_block("fips", PT128, CT128, 10, 15, 0, 11, 0);
    // Key stall of three cycles at round-key index 5.
    run_block("stall", PT128, CT128, 10, 5, 3, 14, 0);
    // Output held off for four cycles in DONE.
    run_block("backpressure", PT128, CT128, 10, 15, 0, 11, 4);

    // Reset while waiting on round key 7.
    in_block = PT128; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("midreset_idx_before", o_idx, 7);
    rst = 1'b1;
    tick();
    check_reset("midreset");
    rst = 1'b0;
    tick();
    check_reset("midreset_after");
    $display("block midreset: aborted at rk_idx 7");
    run_block("after_reset", PT128, CT128, 10, 15, 0, 11, 0);

    // Rijndael-256/256 instance.
    sel = 1'b1; #1;
    run_block("rijndael256", PTB, ctb, 14, 15, 0, 15, 0);
    sel = 1'b0; #1;

    // Two blocks offered back to back with the output always ready.
    first_out = -1; second_out = -1;
    in_block = PT128; in_valid = 1'b1; out_ready = 1'b1; rkv = 1'b1;
    for (int c = 1; c <= 60 && second_out < 0; c++) begin
      tick();
      if (c == 1) in_block = PT2;
      if (o_valid === 1'b1) begin
        if (first_out < 0) begin
          first_out = c;
          chk("b2b_ct1", o_block, CT128);
          chk("b2b_ready_in_done", o_in_ready, B2B_READY);
        end else begin
          second_out = c;
          chk("b2b_ct2", o_block, ct2);
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_gap", second_out - first_out, GAP);
    tick();
    out_ready = 1'b0;
    chk("b2b_end_busy", o_busy, 0);
    chk("b2b_end_valid", o_valid, 0);
    $display("block b2b: outputs at cycles %0d and %0d", first_out, second_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
